// File: rtl/food_tracker.sv
// Authoritative food location for the snake game: places food on unoccupied
// cells via an occupancy query, detects the head eating it and keeps the score.
module food_tracker #(
  parameter int GRID      = 10,
  parameter int X_MIN     = 20,
  parameter int X_MAX     = 620,
  parameter int Y_MIN     = 20,
  parameter int Y_MAX     = 460,
  parameter int MAX_TRIES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       restart,
  input  logic [9:0] head_x,
  input  logic [8:0] head_y,
  input  logic [9:0] cand_x,
  input  logic [8:0] cand_y,
  output logic       occ_req,
  output logic [9:0] occ_x,
  output logic [8:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic [9:0] food_x,
  output logic [8:0] food_y,
  output logic       food_valid,
  output logic       eaten,
  output logic [7:0] score
);

  localparam int TRY_W = (MAX_TRIES > 2) ? $clog2(MAX_TRIES) : 1;

  localparam logic [9:0]       X_MIN_C  = 10'(X_MIN);
  localparam logic [9:0]       X_MAX_C  = 10'(X_MAX);
  localparam logic [8:0]       Y_MIN_C  = 9'(Y_MIN);
  localparam logic [8:0]       Y_MAX_C  = 9'(Y_MAX);
  localparam logic [9:0]       GRID_X   = 10'(GRID);
  localparam logic [8:0]       GRID_Y   = 9'(GRID);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_QUERY  = 2'd1,
    S_STEP   = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [9:0]       food_x_r;
  logic [8:0]       food_y_r;
  logic [9:0]       step_x_s;
  logic [8:0]       step_y_s;
  logic [TRY_W-1:0] tries_r;
  logic [7:0]       score_r;
  logic             eaten_r;
  logic             occ_req_r;
  logic             food_valid_r;
  logic             eat_s;

  function automatic logic [9:0] clamp_x(input logic [9:0] v);
    logic [9:0] r;
    if (v < X_MIN_C) begin
      r = X_MIN_C;
    end else if (v > X_MAX_C) begin
      r = X_MAX_C;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [8:0] clamp_y(input logic [8:0] v);
    logic [8:0] r;
    if (v < Y_MIN_C) begin
      r = Y_MIN_C;
    end else if (v > Y_MAX_C) begin
      r = Y_MAX_C;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Next-state decode; restart overrides everything, including an eat.
  always_comb begin
    state_nx_s = state_r;
    eat_s      = 1'b0;
    case (state_r)
      S_LOAD:  state_nx_s = S_QUERY;
      S_QUERY: begin
        if (occ_ack) begin
          if (occ_hit && (tries_r != TRY_LAST)) begin
            state_nx_s = S_STEP;
          end else begin
            state_nx_s = S_ACTIVE;
          end
        end else begin
          state_nx_s = S_QUERY;
        end
      end
      S_STEP:  state_nx_s = S_QUERY;
      S_ACTIVE: begin
        if (tick && (head_x == food_x_r) && (head_y == food_y_r)) begin
          eat_s      = 1'b1;
          state_nx_s = S_LOAD;
        end else begin
          state_nx_s = S_ACTIVE;
        end
      end
      default: state_nx_s = S_LOAD;
    endcase
    if (restart) begin
      state_nx_s = S_LOAD;
      eat_s      = 1'b0;
    end else begin
      eat_s      = eat_s;
    end
  end

  // Raster-order advance to the next cell, wrapping at the right and bottom edges.
  always_comb begin
    step_x_s = food_x_r + GRID_X;
    step_y_s = food_y_r;
    if (food_x_r == X_MAX_C) begin
      step_x_s = X_MIN_C;
      if (food_y_r == Y_MAX_C) begin
        step_y_s = Y_MIN_C;
      end else begin
        step_y_s = food_y_r + GRID_Y;
      end
    end else begin
      step_y_s = food_y_r;
    end
  end

  // State register and status outputs, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_LOAD;
      occ_req_r    <= 1'b0;
      food_valid_r <= 1'b0;
      eaten_r      <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      occ_req_r    <= (state_nx_s == S_QUERY);
      food_valid_r <= (state_nx_s == S_ACTIVE);
      eaten_r      <= eat_s;
    end
  end

  // Food position and retry counter only move in LOAD and STEP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      food_x_r <= X_MIN_C;
      food_y_r <= Y_MIN_C;
      tries_r  <= '0;
    end else begin
      case (state_r)
        S_LOAD: begin
          food_x_r <= clamp_x(cand_x);
          food_y_r <= clamp_y(cand_y);
          tries_r  <= '0;
        end
        S_STEP: begin
          food_x_r <= step_x_s;
          food_y_r <= step_y_s;
          tries_r  <= tries_r + TRY_W'(1);
        end
        default: begin
          food_x_r <= food_x_r;
          food_y_r <= food_y_r;
          tries_r  <= tries_r;
        end
      endcase
    end
  end

  // Saturating score counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_r <= 8'd0;
    end else if (restart) begin
      score_r <= 8'd0;
    end else if (eat_s && (score_r != 8'hFF)) begin
      score_r <= score_r + 8'd1;
    end else begin
      score_r <= score_r;
    end
  end

  assign occ_req    = occ_req_r;
  assign occ_x      = food_x_r;
  assign occ_y      = food_y_r;
  assign food_x     = food_x_r;
  assign food_y     = food_y_r;
  assign food_valid = food_valid_r;
  assign eaten      = eaten_r;
  assign score      = score_r;

endmodule

// File: tb/tb_food_tracker.sv
// Directed self-checking bench for food_tracker with a scripted occupancy responder.
module tb_food_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       restart;
  logic [9:0] head_x;
  logic [8:0] head_y;
  logic [9:0] cand_x;
  logic [8:0] cand_y;
  logic       occ_req;
  logic [9:0] occ_x;
  logic [8:0] occ_y;
  logic       occ_ack;
  logic       occ_hit;
  logic [9:0] food_x;
  logic [8:0] food_y;
  logic       food_valid;
  logic       eaten;
  logic [7:0] score;

  int total = 0;
  int bad   = 0;

  // responder bookkeeping
  int         hits_left = 0;
  int         acks      = 0;
  int         nq        = 0;
  logic       req_seen  = 1'b0;
  logic [9:0] qx [0:127];
  logic [8:0] qy [0:127];

  food_tracker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .restart    (restart),
    .head_x     (head_x),
    .head_y     (head_y),
    .cand_x     (cand_x),
    .cand_y     (cand_y),
    .occ_req    (occ_req),
    .occ_x      (occ_x),
    .occ_y      (occ_y),
    .occ_ack    (occ_ack),
    .occ_hit    (occ_hit),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .eaten      (eaten),
    .score      (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: account for the query answered at this edge, then log new queries.
  task automatic cyc();
    logic consumed;
    @(posedge clk);
    consumed = req_seen && occ_ack;
    if (consumed) begin
      acks++;
      if (hits_left > 0) hits_left--;
    end
    #1;
    if (occ_req && (!req_seen || consumed)) begin
      qx[nq] = occ_x;
      qy[nq] = occ_y;
      if (nq < 127) nq++;
    end
    req_seen = occ_req;
    occ_hit  = (hits_left > 0);
  endtask

  task automatic wait_valid(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (food_valid) break;
      cyc();
    end
    check(tag, 32'(food_valid), 32'd1);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    tick    = 1'b0;
    restart = 1'b0;
    head_x  = 10'd0;
    head_y  = 9'd0;
    cand_x  = 10'd300;
    cand_y  = 9'd200;
    occ_ack = 1'b1;
    occ_hit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_food_x", 32'(food_x), 32'd20);
    check("rst_food_y", 32'(food_y), 32'd20);
    check("rst_valid", 32'(food_valid), 32'd0);
    check("rst_req", 32'(occ_req), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_eaten", 32'(eaten), 32'd0);

    // first placement: LOAD, QUERY, ACTIVE
    rst_n = 1'b1;
    cyc();
    check("load_x", 32'(food_x), 32'd300);
    check("load_y", 32'(food_y), 32'd200);
    check("load_req", 32'(occ_req), 32'd1);
    check("load_valid", 32'(food_valid), 32'd0);
    check("load_occ_x", 32'(occ_x), 32'd300);
    cyc();
    check("place_valid", 32'(food_valid), 32'd1);
    check("place_req", 32'(occ_req), 32'd0);
    check("place_x", 32'(food_x), 32'd300);
    check("place_y", 32'(food_y), 32'd200);
    check("place_score", 32'(score), 32'd0);
    check("place_eaten", 32'(eaten), 32'd0);

    // clamp
    cand_x = 10'd5;
    cand_y = 9'd470;
    do_restart();
    wait_valid("clamp_valid", 20);
    check("clamp_x", 32'(food_x), 32'd20);
    check("clamp_y", 32'(food_y), 32'd460);

    // hit with wrap: two hits then a free cell
    cand_x    = 10'd620;
    cand_y    = 9'd460;
    hits_left = 2;
    nq        = 0;
    do_restart();
    wait_valid("wrap_valid", 40);
    check("wrap_nq", 32'(nq), 32'd3);
    check("wrap_q0x", 32'(qx[0]), 32'd620);
    check("wrap_q0y", 32'(qy[0]), 32'd460);
    check("wrap_q1x", 32'(qx[1]), 32'd20);
    check("wrap_q1y", 32'(qy[1]), 32'd20);
    check("wrap_q2x", 32'(qx[2]), 32'd30);
    check("wrap_q2y", 32'(qy[2]), 32'd20);
    check("wrap_x", 32'(food_x), 32'd30);
    check("wrap_y", 32'(food_y), 32'd20);

    // responder wait: occ_req holds until ack
    cand_x  = 10'd100;
    cand_y  = 9'd100;
    occ_ack = 1'b0;
    do_restart();
    cyc();
    cyc();
    cyc();
    check("wait_req", 32'(occ_req), 32'd1);
    check("wait_valid0", 32'(food_valid), 32'd0);
    check("wait_occ_y", 32'(occ_y), 32'd100);
    occ_ack = 1'b1;
    cyc();
    check("wait_done_valid", 32'(food_valid), 32'd1);
    check("wait_done_req", 32'(occ_req), 32'd0);

    // MAX_TRIES: every query hits; 64th cell is accepted (20,20)+63 steps
    cand_x    = 10'd20;
    cand_y    = 9'd20;
    hits_left = 1000;
    acks      = 0;
    do_restart();
    wait_valid("max_valid", 400);
    check("max_acks", 32'(acks), 32'd64);
    check("max_x", 32'(food_x), 32'd40);
    check("max_y", 32'(food_y), 32'd30);
    hits_left = 0;
    occ_hit   = 1'b0;

    // eat, with tick held through LOAD/QUERY where it must be ignored
    cand_x = 10'd300;
    cand_y = 9'd200;
    do_restart();
    wait_valid("eat_pre_valid", 20);
    head_x = 10'd300;
    head_y = 9'd200;
    tick   = 1'b1;
    cyc();
    check("eat_pulse", 32'(eaten), 32'd1);
    check("eat_valid", 32'(food_valid), 32'd0);
    check("eat_score", 32'(score), 32'd1);
    cyc();
    check("eat_pulse_end", 32'(eaten), 32'd0);
    check("eat_tick_load", 32'(score), 32'd1);
    cyc();
    check("eat_replaced", 32'(food_valid), 32'd1);
    check("eat_tick_query", 32'(score), 32'd1);
    check("eat_no_repulse", 32'(eaten), 32'd0);
    tick = 1'b0;

    // tick with head off the food
    head_x = 10'd310;
    tick   = 1'b1;
    cyc();
    tick = 1'b0;
    check("miss_eaten", 32'(eaten), 32'd0);
    check("miss_score", 32'(score), 32'd1);
    check("miss_valid", 32'(food_valid), 32'd1);

    // saturation
    head_x = 10'd300;
    for (int i = 0; i < 260; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      wait_valid("sat_valid", 20);
    end
    check("sat_score", 32'(score), 32'd255);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("sat_pulse", 32'(eaten), 32'd1);
    check("sat_hold", 32'(score), 32'd255);
    wait_valid("sat_valid2", 20);

    // restart beats a simultaneous eat
    tick    = 1'b1;
    restart = 1'b1;
    cyc();
    tick    = 1'b0;
    restart = 1'b0;
    check("rve_eaten", 32'(eaten), 32'd0);
    check("rve_score", 32'(score), 32'd0);
    check("rve_valid", 32'(food_valid), 32'd0);
    cyc();
    check("rve_load_req", 32'(occ_req), 32'd1);
    wait_valid("rve_valid2", 20);

    // reset in the middle of a query
    tick = 1'b1;
    cyc();
    tick    = 1'b0;
    occ_ack = 1'b0;
    cyc();
    cyc();
    check("mid_req_pre", 32'(occ_req), 32'd1);
    check("mid_score_pre", 32'(score), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_req", 32'(occ_req), 32'd0);
    check("mid_valid", 32'(food_valid), 32'd0);
    check("mid_score", 32'(score), 32'd0);
    check("mid_food_x", 32'(food_x), 32'd20);
    check("mid_food_y", 32'(food_y), 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/food_tracker.md
# food_tracker

Consumes the candidate grid coordinates from the food position generator and turns them into the single authoritative food location for the snake game. It places food only on cells the snake body does not occupy, using a request/acknowledge query to the body-occupancy logic. It detects when the snake head lands on the food, pulses an eat event, keeps the score, and re-places the food. It sits between the random coordinate source, the snake body/movement logic and the VGA renderer.

## Interface
- GRID, 10, cell pitch in pixels; also the step size when a placement is retried
- X_MIN, 20, lowest legal food x
- X_MAX, 620, highest legal food x
- Y_MIN, 20, lowest legal food y
- Y_MAX, 460, highest legal food y
- MAX_TRIES, 64, occupancy queries per placement before food is accepted unconditionally
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle game-step strobe; head coordinates are valid on this cycle
- restart  in  1  one-cycle synchronous game restart
- head_x  in  10  snake head x
- head_y  in  9  snake head y
- cand_x  in  10  candidate food x from the random generator
- cand_y  in  9  candidate food y from the random generator
- occ_req  out  1  occupancy query request
- occ_x  out  10  x coordinate being queried (equals food_x)
- occ_y  out  9  y coordinate being queried (equals food_y)
- occ_ack  in  1  query answered this cycle
- occ_hit  in  1  queried cell is occupied by the body; sampled only when occ_ack=1
- food_x  out  10  current food x
- food_y  out  9  current food y
- food_valid  out  1  food is placed and may be drawn or eaten
- eaten  out  1  one-cycle pulse when the food is eaten
- score  out  8  foods eaten, saturating

## Operation
- The block has four states: LOAD, QUERY, STEP and ACTIVE.
- **Reset values:** state=LOAD, food_x=X_MIN, food_y=Y_MIN, score=0, tries=0, food_valid=0, eaten=0, occ_req=0.
- **LOAD** (1 cycle)
  - food_x <= clamp(cand_x, X_MIN, X_MAX); food_y <= clamp(cand_y, Y_MIN, Y_MAX).
  - tries <= 0.
  - Next state is QUERY.
- **QUERY**
  - occ_req=1; occ_x/occ_y track food_x/food_y.
  - occ_req stays high until occ_ack is seen. An ack in the first QUERY cycle is legal.
  - On ack with occ_hit=1 and tries < MAX_TRIES-1, go to STEP.
  - On ack with occ_hit=0, or with tries = MAX_TRIES-1, go to ACTIVE.
- **STEP** (1 cycle)
  - food_x <= food_x+GRID. If food_x = X_MAX, food_x wraps to X_MIN and food_y advances by GRID.
  - food_y wraps from Y_MAX to Y_MIN.
  - tries <= tries+1.
  - Next state is QUERY.
- **ACTIVE**
  - food_valid=1.
  - On tick with head_x==food_x and head_y==food_y: eaten=1 for the next cycle, score <= score+1 (holds at 255), next state is LOAD.
- **Ignored inputs:** tick is ignored outside ACTIVE. occ_ack/occ_hit are ignored outside QUERY.
- **restart** (any state)
  - score <= 0, eaten <= 0, next state is LOAD.
  - restart has priority over a simultaneous eat: no eaten pulse, no score increment.
- **Arithmetic:** all compares are exact and unsigned. Clamping is done in the input widths.
- **Reset mid-operation:** asserting rst_n low returns all outputs to their reset values immediately, including occ_req.

## Timing
- The first LOAD is the first rising edge after rst_n deasserts. QUERY (occ_req=1) starts on the next cycle.
- **Placement latency, zero-wait responder, no hits:** LOAD → QUERY → ACTIVE. food_valid rises 2 cycles after LOAD.
- Each hit adds 2 cycles (STEP + QUERY) plus responder wait cycles.
- **Eat:** with tick+match at edge N, eaten=1, food_valid=0 and score updated after edge N. eaten is high for exactly one cycle.
- food_x/food_y change only in LOAD and STEP, so they are stable whenever food_valid=1.
- occ_req is registered and deasserts on the cycle after the ack is sampled.
- score is registered and changes at most once per eat.

## Test plan
- **Reset and first placement:** rst_n low then high, cand=(300,200), occ_ack=1/occ_hit=0 immediately.
  - Expect food=(300,200) and food_valid=1 two cycles after LOAD.
  - Expect score=0 and eaten=0 throughout.
- **Clamp:** cand=(5,470), no hits → food=(20,460).
- **Hit with wrap:** cand=(620,460), occ_hit=1 for 2 queries, then 0.
  - Expect queries at (620,460), (20,20), (30,20).
  - Expect final food=(30,20).
- **MAX_TRIES:** occ_hit held at 1 → exactly 64 acks, then food_valid=1 at the 64th queried cell.
- **Eat and saturation:**
  - tick with head=food → one-cycle eaten pulse, score+1, food_valid drops, then re-placement.
  - Preload 255 eats → score stays 255.
  - tick with head≠food → no event.
- **Restart vs eat:** restart on the same cycle as a matching tick → score=0, no eaten pulse, state LOAD.
- **Reset mid-QUERY:** rst_n low → occ_req=0 and food_valid=0 asynchronously.
